ysyx_041514_alu_mul_ctrl: RTL and testbench

//  Sequencer between the EXU and the multi-cycle radix-4 booth multiplier. Decodes RV64M multiply ops,

---
 rtl/ysyx_041514_alu_mul_ctrl_pkg.sv | 59 +++++
 rtl/ysyx_041514_mul_result_cache.sv | 57 +++++
 rtl/ysyx_041514_alu_mul_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ysyx_041514_alu_mul_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041514_alu_mul_ctrl_pkg.sv
// Shared definitions for the RV64M multiply sequencer: op codes, FSM states and op decode.
`default_nettype none

package ysyx_041514_alu_mul_ctrl_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_LO = 2'd0,
    SEL_HI = 2'd1,
    SEL_W  = 2'd2
  } res_sel_t;

  typedef struct packed {
    res_sel_t sel;
    logic     rs1_signed;
    logic     rs2_signed;
  } op_dec_t;

  // Reserved encodings 5-7 fall through to the MUL defaults.
  function automatic op_dec_t decode_op(input logic [2:0] op);
    op_dec_t d;
    d.sel        = SEL_LO;
    d.rs1_signed = 1'b1;
    d.rs2_signed = 1'b1;
    case (op)
      OP_MUL:    d.sel = SEL_LO;
      OP_MULH:   d.sel = SEL_HI;
      OP_MULHSU: begin
        d.sel        = SEL_HI;
        d.rs2_signed = 1'b0;
      end
      OP_MULHU:  begin
        d.sel        = SEL_HI;
        d.rs1_signed = 1'b0;
        d.rs2_signed = 1'b0;
      end
      OP_MULW:   d.sel = SEL_W;
      default:   d.sel = SEL_LO;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_041514_mul_result_cache.sv
// Single-entry product cache keyed on operands and signedness; cleared only by rst.
`default_nettype none

module ysyx_041514_mul_result_cache #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [XLEN-1:0]   fill_rs1,
  input  logic [XLEN-1:0]   fill_rs2,
  input  logic              fill_rs1_signed,
  input  logic              fill_rs2_signed,
  input  logic [2*XLEN-1:0] fill_prod,
  input  logic [XLEN-1:0]   look_rs1,
  input  logic [XLEN-1:0]   look_rs2,
  input  logic              look_rs1_signed,
  input  logic              look_rs2_signed,
  output logic              hit,
  output logic [2*XLEN-1:0] prod
);

  logic              entry_valid;
  logic [XLEN-1:0]   tag_rs1;
  logic [XLEN-1:0]   tag_rs2;
  logic              tag_rs1_signed;
  logic              tag_rs2_signed;
  logic [2*XLEN-1:0] entry_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid    <= 1'b0;
      tag_rs1        <= '0;
      tag_rs2        <= '0;
      tag_rs1_signed <= 1'b0;
      tag_rs2_signed <= 1'b0;
      entry_prod     <= '0;
    end else if (fill) begin
      entry_valid    <= 1'b1;
      tag_rs1        <= fill_rs1;
      tag_rs2        <= fill_rs2;
      tag_rs1_signed <= fill_rs1_signed;
      tag_rs2_signed <= fill_rs2_signed;
      entry_prod     <= fill_prod;
    end
  end

  assign hit = entry_valid
             && (tag_rs1 == look_rs1)
             && (tag_rs2 == look_rs2)
             && (tag_rs1_signed == look_rs1_signed)
             && (tag_rs2_signed == look_rs2_signed);
  assign prod = entry_prod;

endmodule

`default_nettype wire

// File: rtl/ysyx_041514_alu_mul_ctrl.sv
// EXU-to-booth-multiplier sequencer: decode, hold-valid launch, result select, buffered response.
// Optional result cache enabled by defining YSYX_041514_MUL_RESULT_CACHE_EN.
`default_nettype none

module ysyx_041514_alu_mul_ctrl
  import ysyx_041514_alu_mul_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [OP_W-1:0]   req_op_i,
  input  logic [XLEN-1:0]   req_rs1_i,
  input  logic [XLEN-1:0]   req_rs2_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_data_o,
  output logic              mul_valid_o,
  output logic [XLEN-1:0]   mul_rs1_o,
  output logic [XLEN-1:0]   mul_rs2_o,
  output logic              mul_rs1_signed_o,
  output logic              mul_rs2_signed_o,
  input  logic              mul_ready_i,
  input  logic [2*XLEN-1:0] mul_out_i
);

  state_t            state;
  state_t            state_nxt;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic              rs1_signed_q;
  logic              rs2_signed_q;
  res_sel_t          sel_q;
  logic [XLEN-1:0]   resp_q;

  op_dec_t           req_dec;
  logic              accept;
  logic              mul_done;
  logic              cache_hit;
  logic [2*XLEN-1:0] cache_prod;

  function automatic logic [XLEN-1:0] pick_result(input res_sel_t sel, input logic [2*XLEN-1:0] p);
    logic [XLEN-1:0] r;
    case (sel)
      SEL_HI:  r = p[2*XLEN-1:XLEN];
      SEL_W:   r = {{(XLEN-32){p[31]}}, p[31:0]};
      default: r = p[XLEN-1:0];
    endcase
    return r;
  endfunction

  assign req_dec  = decode_op(req_op_i[2:0]);
  assign accept   = (state == ST_IDLE) && req_valid_i && !flush_i;
  // A done pulse coincident with flush is discarded, so it neither responds nor fills the cache.
  assign mul_done = (state == ST_BUSY) && mul_ready_i && !flush_i;

`ifdef YSYX_041514_MUL_RESULT_CACHE_EN
  ysyx_041514_mul_result_cache #(
    .XLEN (XLEN)
  ) u_cache (
    .clk             (clk),
    .rst             (rst),
    .fill            (mul_done),
    .fill_rs1        (rs1_q),
    .fill_rs2        (rs2_q),
    .fill_rs1_signed (rs1_signed_q),
    .fill_rs2_signed (rs2_signed_q),
    .fill_prod       (mul_out_i),
    .look_rs1        (req_rs1_i),
    .look_rs2        (req_rs2_i),
    .look_rs1_signed (req_dec.rs1_signed),
    .look_rs2_signed (req_dec.rs2_signed),
    .hit             (cache_hit),
    .prod            (cache_prod)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_prod = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = cache_hit ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_nxt = ST_ABORT;
        end else if (mul_ready_i) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush_i || resp_ready_i) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ABORT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mul_valid_o  = 1'b0;
    case (state)
      ST_IDLE: req_ready_o  = 1'b1;
      // Drop valid on the done pulse so the multiplier does not relaunch from its idle state.
      ST_BUSY: mul_valid_o  = !mul_ready_i;
      ST_DONE: resp_valid_o = !flush_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs1_signed_q <= 1'b0;
      rs2_signed_q <= 1'b0;
      sel_q        <= SEL_LO;
      resp_q       <= '0;
    end else begin
      if (accept) begin
        rs1_q        <= req_rs1_i;
        rs2_q        <= req_rs2_i;
        rs1_signed_q <= req_dec.rs1_signed;
        rs2_signed_q <= req_dec.rs2_signed;
        sel_q        <= req_dec.sel;
        if (cache_hit) begin
          resp_q <= pick_result(req_dec.sel, cache_prod);
        end
      end
      if (mul_done) begin
        resp_q <= pick_result(sel_q, mul_out_i);
      end
    end
  end

  assign resp_data_o      = resp_q;
  assign mul_rs1_o        = rs1_q;
  assign mul_rs2_o        = rs2_q;
  assign mul_rs1_signed_o = rs1_signed_q;
  assign mul_rs2_signed_o = rs2_signed_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_041514_alu_mul_ctrl.sv
// Directed bench for the multiply sequencer with a behavioural fixed-latency multiplier.
`default_nettype none

module tb_ysyx_041514_alu_mul_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [63:0]  req_rs1;
  logic [63:0]  req_rs2;
  logic         flush;
  logic         resp_valid;
  logic         resp_ready;
  logic [63:0]  resp_data;
  logic         mul_valid;
  logic [63:0]  mul_rs1;
  logic [63:0]  mul_rs2;
  logic         mul_rs1_signed;
  logic         mul_rs2_signed;
  logic         mul_ready;
  logic [127:0] mul_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_041514_alu_mul_ctrl #(.XLEN(64), .OP_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_i         (req_op),
    .req_rs1_i        (req_rs1),
    .req_rs2_i        (req_rs2),
    .flush_i          (flush),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_data_o      (resp_data),
    .mul_valid_o      (mul_valid),
    .mul_rs1_o        (mul_rs1),
    .mul_rs2_o        (mul_rs2),
    .mul_rs1_signed_o (mul_rs1_signed),
    .mul_rs2_signed_o (mul_rs2_signed),
    .mul_ready_i      (mul_ready),
    .mul_out_i        (mul_out)
  );

  // Multiplier stand-in: launches on valid from idle, aborts if valid drops, pulses ready when done.
  logic         m_busy;
  int           m_cnt;
  logic [127:0] m_prod;
  logic [127:0] m_a;
  logic [127:0] m_b;

  assign m_a = {{64{mul_rs1_signed & mul_rs1[63]}}, mul_rs1};
  assign m_b = {{64{mul_rs2_signed & mul_rs2[63]}}, mul_rs2};

  always @(posedge clk) begin
    mul_ready <= 1'b0;
    if (rst) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      mul_out <= '0;
    end else if (!m_busy) begin
      if (mul_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_prod <= m_a * m_b;
      end
    end else if (!mul_valid) begin
      m_busy <= 1'b0;
    end else if (m_cnt == 34) begin
      m_busy    <= 1'b0;
      mul_ready <= 1'b1;
      mul_out   <= m_prod;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic wait_resp(input string tag, input logic [63:0] exp, input bit hit);
    int n = 1;
    int rdy = -100;
    bit mv_at_rdy = 1'b0;
    bit mv_seen = 1'b0;
    while (!resp_valid && n < 45) begin
      if (mul_valid) mv_seen = 1'b1;
      if (mul_ready) begin
        rdy = n;
        mv_at_rdy = mul_valid;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_data"}, resp_data, exp);
    if (hit) begin
      chk({tag, "_hit_lat"}, 64'(n), 64'd1);
      chk({tag, "_hit_mulvalid"}, 64'(mv_seen), 64'd0);
    end else begin
      chk({tag, "_lat_rel"}, 64'(n), 64'(rdy + 1));
      chk({tag, "_lat_bound"}, 64'(n <= 40), 64'd1);
      chk({tag, "_mv_drop"}, 64'(mv_at_rdy), 64'd0);
    end
    if (resp_ready) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
    flush = 1'b0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_mul_valid", 64'(mul_valid), 64'd0);
    chk("rst_mul_rs1", mul_rs1, 64'd0);
    chk("rst_mul_rs2", mul_rs2, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    wait_resp("mul_neg", 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);

    issue(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    wait_resp("mulhu", 64'h1, 1'b0);
    issue(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    chk("mulhsu_s1", 64'(mul_rs1_signed), 64'd1);
    chk("mulhsu_s2", 64'(mul_rs2_signed), 64'd0);
    chk("mulhsu_busy_mv", 64'(mul_valid), 64'd1);
    wait_resp("mulhsu", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_resp("mulh", 64'h0, 1'b0);

    issue(3'd4, 64'h8000_0000, 64'd1);
    wait_resp("mulw", 64'hFFFF_FFFF_8000_0000, 1'b0);
    issue(3'd7, 64'd6, 64'd7);
    wait_resp("op7", 64'd42, 1'b0);

    // Stalled response, with the next request already waiting.
    resp_ready = 1'b0;
    issue(3'd0, 64'd5, 64'd5);
    wait_resp("stall", 64'd25, 1'b0);
    req_op = 3'd7; req_rs1 = 64'd11; req_rs2 = 64'd13; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", resp_data, 64'd25);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("hs_resp_valid", 64'(resp_valid), 64'd0);
    chk("hs_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("post_hs_accept", 64'(req_ready), 64'd0);
    wait_resp("pipe", 64'd143, 1'b0);

    // Flush in IDLE blocks the same-cycle request.
    flush = 1'b1;
    issue(3'd0, 64'd8, 64'd8);
    flush = 1'b0;
    chk("idle_flush_ready", 64'(req_ready), 64'd1);
    chk("idle_flush_mv", 64'(mul_valid), 64'd0);

    // Flush mid-operation.
    issue(3'd0, 64'd7, 64'd9);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("abort_mv", 64'(mul_valid), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("abort_idle", 64'(req_ready), 64'd1);
    seen = 0;
    repeat (45) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_resp", 64'(seen), 64'd0);
    issue(3'd0, 64'd3, 64'd4);
    wait_resp("after_abort", 64'd12, 1'b0);

    // Flush coincident with the done pulse.
    issue(3'd0, 64'd2, 64'd2);
    seen = 0;
    while (!mul_ready && seen < 45) begin
      @(negedge clk);
      seen++;
    end
    chk("coinc_ready_seen", 64'(mul_ready), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    repeat (5) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("coinc_no_resp", 64'(seen), 64'd0);
    chk("coinc_idle", 64'(req_ready), 64'd1);

    // Flush while the response is pending.
    resp_ready = 1'b0;
    issue(3'd0, 64'd9, 64'd9);
    wait_resp("fdone", 64'd81, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    resp_ready = 1'b1;
    chk("fdone_dropped", 64'(resp_valid), 64'd0);
    chk("fdone_idle", 64'(req_ready), 64'd1);

`ifdef YSYX_041514_MUL_RESULT_CACHE_EN
    issue(3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    wait_resp("c_mulh", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    wait_resp("c_hit", 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
    issue(3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd6);
    wait_resp("c_miss", 64'hFFFF_FFFF_FFFF_FFEE, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd6);
    wait_resp("c_after_rst", 64'hFFFF_FFFF_FFFF_FFEE, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
